// File: rtl/time_set_pkg.sv
// Shared types and digit limits for the time/alarm setting controller.
package time_set_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_E_H1   = 3'd1,
    S_E_H0   = 3'd2,
    S_E_M1   = 3'd3,
    S_E_M0   = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  localparam logic [1:0] DIG_H1 = 2'd0;
  localparam logic [1:0] DIG_H0 = 2'd1;
  localparam logic [1:0] DIG_M1 = 2'd2;
  localparam logic [1:0] DIG_M0 = 2'd3;

  localparam logic [3:0] H1_MAX       = 4'd2;
  localparam logic [3:0] H0_MAX       = 4'd9;
  localparam logic [3:0] H0_MAX_AT_20 = 4'd3;
  localparam logic [3:0] M1_MAX       = 4'd5;
  localparam logic [3:0] M0_MAX       = 4'd9;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

endpackage

// File: rtl/time_digit_inc.sv
// Wrapping single-digit increment; anything at or above max (including
// out-of-range seeds) wraps to 0.
module time_digit_inc (
  input  logic [3:0] digit,
  input  logic [3:0] max_val,
  output logic [3:0] digit_next
);

  assign digit_next = (digit >= max_val) ? 4'd0 : digit + 4'd1;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time/alarm editor feeding the clock core's load interface.
// Valid/ready does not apply: buttons are level inputs acting once per edge.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       btn_set_time,
  input  logic       btn_set_alarm,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_cancel,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic       edit_target,
  output logic [1:0] digit_sel,
  output state_t     state_dbg
);

  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT_S - 1);

  state_t     state;
  hhmm_t      committed;
  hhmm_t      shadow;
  logic [5:0] tmo_cnt;
  logic [3:0] inc_digit;
  logic [3:0] inc_max;
  logic [3:0] inc_result;
  logic       abandon;

  assign state_dbg = state;

  always_comb begin
    inc_digit = M_in0;
    inc_max   = M0_MAX;
    case (digit_sel)
      DIG_H1: begin
        inc_digit = {2'b00, H_in1};
        inc_max   = H1_MAX;
      end
      DIG_H0: begin
        inc_digit = H_in0;
        inc_max   = (H_in1 == 2'd2) ? H0_MAX_AT_20 : H0_MAX;
      end
      DIG_M1: begin
        inc_digit = M_in1;
        inc_max   = M1_MAX;
      end
      default: begin
        inc_digit = M_in0;
        inc_max   = M0_MAX;
      end
    endcase
  end

  time_digit_inc u_inc (
    .digit      (inc_digit),
    .max_val    (inc_max),
    .digit_next (inc_result)
  );

  // Timeout only fires on an edge with no inc/next activity.
  assign abandon = btn_cancel || (!btn_next && !btn_inc && (tmo_cnt == TMO_LAST));

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      H_in1       <= '0;
      H_in0       <= '0;
      M_in1       <= '0;
      M_in0       <= '0;
      LD_time     <= 1'b0;
      LD_alarm    <= 1'b0;
      editing     <= 1'b0;
      edit_target <= 1'b0;
      digit_sel   <= DIG_H1;
      committed   <= '0;
      shadow      <= '0;
      tmo_cnt     <= '0;
    end else begin
      LD_time  <= 1'b0;
      LD_alarm <= 1'b0;
      case (state)
        S_IDLE: begin
          tmo_cnt   <= '0;
          digit_sel <= DIG_H1;
          if (btn_set_time) begin
            {H_in1, H_in0, M_in1, M_in0} <= {cur_h1, cur_h0, cur_m1, cur_m0};
            edit_target <= 1'b0;
            editing     <= 1'b1;
            state       <= S_E_H1;
          end else if (btn_set_alarm) begin
            {H_in1, H_in0, M_in1, M_in0} <= shadow;
            edit_target <= 1'b1;
            editing     <= 1'b1;
            state       <= S_E_H1;
          end
        end
        S_E_H1, S_E_H0, S_E_M1, S_E_M0: begin
          if (abandon) begin
            {H_in1, H_in0, M_in1, M_in0} <= committed;
            editing   <= 1'b0;
            digit_sel <= DIG_H1;
            tmo_cnt   <= '0;
            state     <= S_IDLE;
          end else if (btn_next) begin
            tmo_cnt <= '0;
            case (state)
              S_E_H1: begin
                state     <= S_E_H0;
                digit_sel <= DIG_H0;
              end
              S_E_H0: begin
                state     <= S_E_M1;
                digit_sel <= DIG_M1;
              end
              S_E_M1: begin
                state     <= S_E_M0;
                digit_sel <= DIG_M0;
              end
              default: begin
                state    <= S_COMMIT;
                editing  <= 1'b0;
                LD_time  <= ~edit_target;
                LD_alarm <= edit_target;
              end
            endcase
          end else if (btn_inc) begin
            tmo_cnt <= '0;
            case (digit_sel)
              DIG_H1: begin
                H_in1 <= inc_result[1:0];
                // Entering the 20s hours pulls an illegal unit digit down to 3.
                if (inc_result[1:0] == 2'd2 && H_in0 > H0_MAX_AT_20)
                  H_in0 <= H0_MAX_AT_20;
              end
              DIG_H0:  H_in0 <= inc_result;
              DIG_M1:  M_in1 <= inc_result;
              default: M_in0 <= inc_result;
            endcase
          end else begin
            tmo_cnt <= tmo_cnt + 6'd1;
          end
        end
        S_COMMIT: begin
          committed <= {H_in1, H_in0, M_in1, M_in0};
          if (edit_target)
            shadow <= {H_in1, H_in0, M_in1, M_in0};
          digit_sel <= DIG_H1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Button-driven time/alarm setter that drives the clock core's load interface: H_in1, H_in0, M_in1, M_in0, LD_time and LD_alarm.
- Operates in the clock's 1-second domain and seeds edits from the live time (H_out*/M_out*) or from a shadow copy of the last loaded alarm.
- Walks the user digit by digit with range-legal increments, then commits with a single-cycle load pulse.
- Sits between the debounced front-panel buttons and the clock core.

Parameters:
- TIMEOUT_S, 30, clk_1s cycles of button inactivity in an edit state before the edit is abandoned (1..63).

Ports:
- clk_1s  in  1  1 Hz clock, rising edge.
- reset  in  1  asynchronous, active-high.
- btn_set_time  in  1  level, synchronous to clk_1s; request a time edit.
- btn_set_alarm  in  1  level; request an alarm edit.
- btn_inc  in  1  level; increment the selected digit.
- btn_next  in  1  level; advance to the next digit, or commit after M0.
- btn_cancel  in  1  level; abort the edit.
- cur_h1  in  2  live hour tens.
- cur_h0  in  4  live hour units.
- cur_m1  in  4  live minute tens.
- cur_m0  in  4  live minute units.
- H_in1  out  2  load value, hour tens.
- H_in0  out  4  load value, hour units.
- M_in1  out  4  load value, minute tens.
- M_in0  out  4  load value, minute units.
- LD_time  out  1  one-cycle load strobe to the clock core.
- LD_alarm  out  1  one-cycle load strobe to the clock core.
- editing  out  1  high in any edit state.
- edit_target  out  1  0 = time, 1 = alarm.
- digit_sel  out  2  0 = H1, 1 = H0, 2 = M1, 3 = M0; used for display blink.

Behaviour:
- All outputs are registered.
- Reset values:
  - State IDLE.
  - All H_in/M_in outputs 0.
  - LD_time = LD_alarm = 0, editing = 0, edit_target = 0, digit_sel = 0.
  - Alarm shadow = 00:00.
  - Timeout counter = 0.
- FSM states: IDLE, E_H1, E_H0, E_M1, E_M0, COMMIT.
- IDLE:
  - btn_set_time: load the edit registers from cur_*, set edit_target = 0, go to E_H1.
  - btn_set_alarm: load the edit registers from the alarm shadow, set edit_target = 1, go to E_H1.
  - Both asserted: time wins.
  - btn_inc, btn_next and btn_cancel are ignored.
- Edit states. Priority per edge: cancel > next > inc.
  - btn_cancel: go to IDLE, no load. H_in/M_in revert to the last committed values.
  - btn_next: E_H1 -> E_H0 -> E_M1 -> E_M0 -> COMMIT.
  - btn_inc: selected digit +1 with wrap:
    - H1: 0..2.
    - H0: 0..9, or 0..3 when H1 = 2.
    - M1: 0..5.
    - M0: 0..9.
  - When H1 wraps to 2 with H0 > 3, H0 is clamped to 3 on the same edge.
  - A held button acts once per clk_1s edge (auto-repeat at 1 Hz).
- H_in/M_in outputs track the edit registers during edit states and hold the last committed values in IDLE.
- COMMIT:
  - Lasts exactly one cycle.
  - LD_time (target 0) or LD_alarm (target 1) is high for that cycle only.
  - H_in/M_in are stable with the edited values.
  - On target 1, the alarm shadow is updated.
  - Next state IDLE. Buttons are ignored in COMMIT.
- Latency:
  - A button sampled at edge N is reflected in the outputs after edge N.
  - btn_next in E_M0 at edge N: LD high from N to N+1; the clock core loads at N+1; IDLE after N+1.
- Timeout:
  - The counter clears on entry to an edit state and on any edge where btn_inc or btn_next is high.
  - Otherwise it increments each edge in an edit state.
  - When it reaches TIMEOUT_S, go to IDLE with no load, as for cancel.
- editing = 1 in E_* states only, so it is 0 in COMMIT.
- digit_sel is held at 0 in IDLE.
- Reset mid-edit or mid-COMMIT: immediate return to the reset values; no LD pulse escapes.
- Out-of-range cur_* values are loaded as-is; the first inc on that digit wraps it to 0.

Decomposition:
- Package time_set_pkg:
  - State enum.
  - Digit index constants.
  - Limits: H1_MAX = 2, H0_MAX = 9, H0_MAX_AT_20 = 3, M1_MAX = 5, M0_MAX = 9.
- Sub-module time_digit_inc: combinational; takes (digit, max) and returns the wrapped increment. Instantiated once, with the max muxed by digit_sel.

Test Plan:
- Reset, btn_set_time with cur = 13:47 -> editing = 1, digit_sel = 0, H_in = 1,3, M_in = 4,7. Then next ×4 -> a single LD_time pulse with 13:47, then editing = 0.
- Time edit from 19:00: inc H1 once -> H1 = 2, H0 clamped to 3 (23:00). Inc H0 once -> 20:00. Commit -> LD_time with 20:00.
- btn_set_alarm after reset -> seeded 00:00. Inc M1 ×7 -> M1 = 1 (wraps after 5). Commit -> LD_alarm only. A second btn_set_alarm seeds 00:10.
- Edit in E_M1 with cancel, next and inc all high -> IDLE, no LD pulse, outputs revert to the last committed values.
- Enter edit, hold all buttons low for 30 edges -> IDLE at edge 30, no LD. With inc pulsed at edge 20 -> the timeout lands at edge 50.
- Assert reset in COMMIT -> LD_time/LD_alarm are 0 immediately, outputs 0, the shadow is back to 00:00.
